instr_skid_buf: RTL and testbench

INSTR_SKID_BUF -- requirements
Module: instr_skid_buf

---
 rtl/instr_skid_buf_if.sv | 20 ++
 rtl/instr_skid_buf.sv | 51 +++++
 tb/tb_instr_skid_buf.sv | 112 +++++++++++
 3 files changed

// File: rtl/instr_skid_buf_if.sv
// instr_skid_buf_if: fetch-to-decode handshake bundle for the instruction skid buffer
interface instr_skid_buf_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;
  logic        flush;
  modport master (
    output if_valid, if_instr, if_pc, id_ready, flush,
    input  if_ready, id_valid, id_instr, id_pc
  );
  modport slave (
    input  if_valid, if_instr, if_pc, id_ready, flush,
    output if_ready, id_valid, id_instr, id_pc
  );
endinterface

// File: rtl/instr_skid_buf.sv
// instr_skid_buf: 2-entry {instr,pc} FIFO between fetch and decode; IBUF_BYPASS_EN adds a zero-latency empty-path bypass
module instr_skid_buf #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0013,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk_i,
  input logic             rst_n_i,
  instr_skid_buf_if.slave b
);
  logic [31:0] instr_q [2];
  logic [31:0] pc_q [2];
  logic        wr_q, wr_d, rd_q, rd_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        push, pop, byp, full;
  // handshake, output muxing and next-state pointers/count
  always_comb begin
    byp = 1'b0;
`ifdef IBUF_BYPASS_EN
    byp = (cnt_q == 2'd0) & b.if_valid & ~b.flush;
`endif
    full = cnt_q == 2'd2;
    b.if_ready = ~full;
    b.id_valid = ((cnt_q != 2'd0) | byp) & ~b.flush;
    b.id_instr = ~b.id_valid ? NOP_WORD : byp ? b.if_instr : instr_q[rd_q];
    b.id_pc = ~b.id_valid ? RESET_PC : byp ? b.if_pc : pc_q[rd_q];
    pop = (cnt_q != 2'd0) & b.id_ready & ~b.flush;
    push = b.if_valid & ~full & ~b.flush & ~(byp & b.id_ready);
    wr_d = b.flush ? 1'b0 : wr_q ^ push;
    rd_d = b.flush ? 1'b0 : rd_q ^ pop;
    cnt_d = b.flush ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
  end
  // pointer and occupancy registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage array; contents are only visible through a nonzero count
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_q[wr_q] <= b.if_instr;
      pc_q[wr_q] <= b.if_pc;
    end
  end
endmodule

// File: tb/tb_instr_skid_buf.sv
// tb_instr_skid_buf: scoreboard bench for instr_skid_buf (honours IBUF_BYPASS_EN)
module tb_instr_skid_buf;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  instr_skid_buf_if bus ();
  instr_skid_buf dut (.clk_i(clk), .rst_n_i(rst_n), .b(bus));
  always #5 clk = ~clk;
`ifdef IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] q_pc [$];
  logic [31:0] pc_r;
  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0003;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic idle_in();
    bus.if_valid = 1'b0;
    bus.if_pc = 32'h0;
    bus.if_instr = 32'h0;
    bus.id_ready = 1'b0;
    bus.flush = 1'b0;
  endtask
  task automatic cyc(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    int  pre;
    logic ev;
    bus.if_valid = v;
    bus.if_pc = pc;
    bus.if_instr = ins(pc);
    bus.id_ready = rdy;
    bus.flush = fl;
    #4;
    pre = q_pc.size();
    chk("if_ready", {31'b0, bus.if_ready}, {31'b0, pre != 2});
    if (fl) q_pc.delete();
    else if (v && pre != 2) q_pc.push_back(pc);
    ev = !fl && (BYP ? q_pc.size() != 0 : pre != 0);
    chk("id_valid", {31'b0, bus.id_valid}, {31'b0, ev});
    if (ev) begin
      chk("id_pc", bus.id_pc, q_pc[0]);
      chk("id_instr", bus.id_instr, ins(q_pc[0]));
      if (rdy) void'(q_pc.pop_front());
    end else begin
      chk("id_instr_nop", bus.id_instr, 32'h0000_0013);
      chk("id_pc_idle", bus.id_pc, 32'h0);
    end
    @(negedge clk);
  endtask
  initial begin
    idle_in();
    #2;
    chk("rst_valid", {31'b0, bus.id_valid}, 32'd0);
    chk("rst_instr", bus.id_instr, 32'h0000_0013);
    chk("rst_pc", bus.id_pc, 32'h0);
    chk("rst_ready", {31'b0, bus.if_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 1, 0);
    cyc(1, 32'h0, 1, 0);
    cyc(1, 32'h4, 1, 0);
    cyc(1, 32'h8, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 32'h100, 0, 0);
    cyc(1, 32'h104, 0, 0);
    cyc(1, 32'h108, 0, 0);
    cyc(1, 32'h108, 0, 0);
    cyc(1, 32'h108, 1, 0);
    cyc(1, 32'h108, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 32'h1F0, 0, 0);
    cyc(1, 32'h1F4, 0, 0);
    cyc(1, 32'h200, 1, 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 32'h2F0, 0, 0);
    cyc(1, 32'h300, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 32'h304, 0, 0);
    idle_in();
    #2;
    rst_n = 1'b0;
    #1;
    q_pc.delete();
    chk("mid_rst_valid", {31'b0, bus.id_valid}, 32'd0);
    chk("mid_rst_instr", bus.id_instr, 32'h0000_0013);
    chk("mid_rst_ready", {31'b0, bus.if_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    pc_r = 32'h1000;
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), pc_r, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      pc_r += 32'h4;
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
